// File: rtl/fxp_pkg.sv
// fxp_pkg: shared types and constants for the fixed-point arithmetic unit
// front end.
//   opcode_e : operation encoding understood by the add/mul/div unit.
//   state_e  : issuer sequencing states.
//   WIDTH, FRAC_BITS : Q8.23 sign-magnitude word format.
package fxp_pkg;

  localparam int WIDTH     = 32;
  localparam int FRAC_BITS = 23;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_DIV = 2'b10,
    OP_ILL = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/fxp_lat_counter.sv
// fxp_lat_counter: loadable down-counter with a zero flag. It times the
// add/mul result latency and, when enabled, the divide watchdog.
// Ports:
//   clk, reset : clock and synchronous active-high reset (count -> 0)
//   load       : load load_val this cycle (wins over dec)
//   load_val   : value to load
//   dec        : decrement by one, saturating at zero
//   zero       : count is zero
module fxp_lat_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: load, saturating decrement, or hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/fxp_op_issuer.sv
// fxp_op_issuer: initiator for the fixed-point add/mul/div unit. Accepts a
// tagged request (valid/ready), drives operands/opcode plus a one-cycle
// alu_start, waits ADD_LAT/MUL_LAT cycles (add/mul) or for alu_done (div),
// and returns the captured result with its tag (valid/ready).
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   req_valid/req_ready               : request handshake
//   req_opcode, req_a, req_b, req_tag : request payload
//   alu_a, alu_b, alu_opcode          : operands/opcode to the unit (held)
//   alu_start                         : one-cycle start pulse
//   alu_result, alu_done              : result and divide-complete from unit
//   rsp_valid/rsp_ready               : response handshake
//   rsp_result, rsp_tag, rsp_err      : response payload
//   busy                              : issuer not idle
// Optional build macro FXP_DIV_TIMEOUT_EN: divide watchdog of DIV_TIMEOUT
// cycles in WAIT; on expiry the response carries result 0 and rsp_err = 1.
module fxp_op_issuer
  import fxp_pkg::*;
#(
  parameter int WIDTH       = fxp_pkg::WIDTH,
  parameter int TAG_W       = 4,
  parameter int ADD_LAT     = 1,
  parameter int MUL_LAT     = 1,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_opcode,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  // Wide enough for both the latency loads and the watchdog limit.
  localparam int CNT_W = $clog2(DIV_TIMEOUT + 16);

  state_e           state_r;
  opcode_e          alu_opcode_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic             alu_start_r;
  logic             req_ready_r;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic [TAG_W-1:0] rsp_tag_r;
  logic             rsp_err_r;
  logic             busy_r;

  logic             cnt_load_s;
  logic             cnt_dec_s;
  logic [CNT_W-1:0] cnt_load_val_s;
  logic             cnt_zero_s;

  // Counter control. It is loaded with LAT-1 in ISSUE so it reads zero in
  // cycle T+LAT; for divide it is loaded with the watchdog limit minus one,
  // so it reads zero in the DIV_TIMEOUT-th WAIT cycle.
  always_comb begin
    cnt_load_s     = 1'b0;
    cnt_dec_s      = 1'b0;
    cnt_load_val_s = {CNT_W{1'b0}};
    case (state_r)
      ISSUE: begin
        cnt_load_s = 1'b1;
        case (alu_opcode_r)
          OP_ADD:  cnt_load_val_s = CNT_W'(ADD_LAT - 1);
          OP_MUL:  cnt_load_val_s = CNT_W'(MUL_LAT - 1);
          OP_DIV:  cnt_load_val_s = CNT_W'(DIV_TIMEOUT - 1);
          default: cnt_load_val_s = {CNT_W{1'b0}};
        endcase
      end
      WAIT:    cnt_dec_s = 1'b1;
      default: cnt_dec_s = 1'b0;
    endcase
  end

  fxp_lat_counter #(
    .CNT_W(CNT_W)
  ) u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  // Issuer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
      alu_opcode_r <= OP_ADD;
      alu_start_r  <= 1'b0;
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= {WIDTH{1'b0}};
      rsp_tag_r    <= {TAG_W{1'b0}};
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // req_ready is high exactly while in IDLE, so req_valid alone
          // completes the handshake here.
          if (req_valid) begin
            alu_a_r      <= req_a;
            alu_b_r      <= req_b;
            alu_opcode_r <= opcode_e'(req_opcode);
            rsp_tag_r    <= req_tag;
            req_ready_r  <= 1'b0;
            busy_r       <= 1'b1;
            if (opcode_e'(req_opcode) == OP_ILL) begin
              rsp_result_r <= {WIDTH{1'b0}};
              rsp_err_r    <= 1'b1;
              rsp_valid_r  <= 1'b1;
              state_r      <= RESP;
            end else begin
              rsp_err_r    <= 1'b0;
              alu_start_r  <= 1'b1;
              state_r      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          alu_start_r <= 1'b0;
          state_r     <= WAIT;
        end
        WAIT: begin
          if (alu_opcode_r == OP_DIV) begin
            // WAIT begins at T+1, so a stale done seen during T is ignored.
            if (alu_done) begin
              rsp_result_r <= alu_result;
              rsp_valid_r  <= 1'b1;
              state_r      <= RESP;
`ifdef FXP_DIV_TIMEOUT_EN
            end else if (cnt_zero_s) begin
              rsp_result_r <= {WIDTH{1'b0}};
              rsp_err_r    <= 1'b1;
              rsp_valid_r  <= 1'b1;
              state_r      <= RESP;
`endif
            end
          end else if (cnt_zero_s) begin
            rsp_result_r <= alu_result;
            rsp_valid_r  <= 1'b1;
            state_r      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          alu_start_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_opcode = alu_opcode_r;
  assign alu_start  = alu_start_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = rsp_result_r;
  assign rsp_tag    = rsp_tag_r;
  assign rsp_err    = rsp_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_fxp_op_issuer.sv
// Scoreboard bench for fxp_op_issuer: expected responses are queued when a
// request is accepted; a monitor pops and compares on each response
// handshake. A small behavioural arithmetic unit supplies results that are
// valid only in the cycle they should be captured.
module tb_fxp_op_issuer;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_opcode = 2'b00;
  logic [31:0] req_a = 32'h0;
  logic [31:0] req_b = 32'h0;
  logic [3:0]  req_tag = 4'h0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_opcode;
  logic        alu_start;
  logic [31:0] alu_result = 32'hDEAD_BEEF;
  logic        alu_done = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic        busy;

  int          vectors = 0;
  int          miscompares = 0;
  int          starts = 0;
  exp_t        sb[$];
  logic [31:0] model_res = 32'h0;
  int          div_delay = 0;

  fxp_op_issuer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .alu_done   (alu_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Arithmetic unit model: result valid only in the capture cycle.
  initial begin
    logic [1:0] op;
    forever begin
      @(negedge clk);
      if (alu_start === 1'b1) begin
        op = alu_opcode;
        starts++;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        if (op != 2'b10) begin
          alu_result = model_res;
          @(posedge clk);
          #1 alu_result = 32'hDEAD_BEEF;
        end else if (div_delay != 0) begin
          repeat (div_delay - 1) @(posedge clk);
          #1;
          alu_done   = 1'b1;
          alu_result = model_res;
          @(posedge clk);
          #1;
          alu_done   = 1'b0;
          alu_result = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got result %08h tag %0h, expected none", rsp_result, rsp_tag);
        end else begin
          e = sb.pop_front();
          chk("rsp_result", rsp_result, e.result);
          chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] er, input logic ee);
    logic ok;
    exp_t e;
    ok = 1'b0;
    req_opcode = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
      @(posedge clk);
    end
    if (ok) begin
      e.result = er; e.tag = tag; e.err = ee;
      sb.push_back(e);
    end
    #1 req_valid = 1'b0;
    chk("accepted", 32'(ok), 32'd1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !rsp_valid) done = 1'b1;
    end
    chk("drain", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    int k;
    logic stable;
    logic quiet;

    // Reset values
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    @(posedge clk);
    #1;

    // 1. Add 1.5 + 2.25 = 3.75
    model_res = 32'h01E0_0000;
    s0 = starts;
    issue(2'b00, 32'h00C0_0000, 32'h0120_0000, 4'd3, 32'h01E0_0000, 1'b0);
    @(negedge clk); chk("add_start_t", 32'(alu_start), 32'd1);
    chk("add_busy", 32'(busy), 32'd1);
    @(negedge clk); chk("add_start_off", 32'(alu_start), 32'd0);
    chk("add_valid_early", 32'(rsp_valid), 32'd0);
    @(negedge clk); chk("add_valid_a3", 32'(rsp_valid), 32'd1);
    drain();
    chk("add_start_once", 32'(starts - s0), 32'd1);

    // 2. Mul 1.5 * 2.0 = 3.0, operands held
    model_res = 32'h0180_0000;
    issue(2'b01, 32'h00C0_0000, 32'h0100_0000, 4'd4, 32'h0180_0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mul_alu_a", alu_a, 32'h00C0_0000);
      chk("mul_alu_b", alu_b, 32'h0100_0000);
      chk("mul_alu_op", 32'(alu_opcode), 32'd1);
    end
    drain();

    // 3. Div with stale done during ISSUE; done at T+20
    alu_done = 1'b1;
    model_res = 32'h0060_0000;
    div_delay = 20;
    issue(2'b10, 32'h0120_0000, 32'h0180_0000, 4'd7, 32'h0060_0000, 1'b0);
    k = 0;
    stable = 1'b1;
    for (int i = 1; i <= 60 && k == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) k = i;
      if (alu_a != 32'h0120_0000 || alu_b != 32'h0180_0000 || alu_opcode != 2'b10) stable = 1'b0;
    end
    chk("div_valid_cycle", 32'(k), 32'd22);
    chk("div_operands_stable", 32'(stable), 32'd1);
    drain();

    // 4. Illegal opcode
    s0 = starts;
    issue(2'b11, 32'h1234_5678, 32'h0000_0042, 4'd9, 32'h0, 1'b1);
    @(negedge clk); chk("ill_valid", 32'(rsp_valid), 32'd1);
    drain();
    chk("ill_no_start", 32'(starts - s0), 32'd0);

    // 5. Backpressure with a pending request
    rsp_ready = 1'b0;
    model_res = 32'h0040_0000;
    issue(2'b00, 32'h0020_0000, 32'h0020_0000, 4'd5, 32'h0040_0000, 1'b0);
    repeat (3) @(negedge clk);
    model_res = 32'h0080_0000;
    req_opcode = 2'b01; req_a = 32'h0040_0000; req_b = 32'h0100_0000;
    req_tag = 4'd6; req_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result != 32'h0040_0000 || rsp_tag != 4'd5 ||
          rsp_err || req_ready) stable = 1'b0;
    end
    chk("bp_stall_stable", 32'(stable), 32'd1);
    chk("bp_q_pending", 32'(sb.size()), 32'd1);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(2'b01, 32'h0040_0000, 32'h0100_0000, 4'd6, 32'h0080_0000, 1'b0);
    drain();

    // 6. Reset mid-divide, late done in IDLE
    model_res = 32'h0060_0000;
    div_delay = 30;
    issue(2'b10, 32'h0120_0000, 32'h0180_0000, 4'd2, 32'h0060_0000, 1'b0);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_alu_b", alu_b, 32'h0);
    chk("mid_rst_alu_op", 32'(alu_opcode), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid || busy || alu_start) quiet = 1'b0;
    end
    chk("post_rst_quiet", 32'(quiet), 32'd1);
    @(posedge clk);
    #1;

`ifdef FXP_DIV_TIMEOUT_EN
    // Divide watchdog
    div_delay = 0;
    issue(2'b10, 32'h0120_0000, 32'h0, 4'd1, 32'h0, 1'b1);
    k = 0;
    for (int i = 1; i <= 200 && k == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) k = i;
    end
    chk("div_timeout_cycle", 32'(k), 32'd66);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fxp_op_issuer.md
Name: fxp_op_issuer

Overview:
Initiator side of the fixed-point arithmetic unit's start/opcode/result interface. It accepts tagged operation requests over a valid/ready port and drives operands, opcode and a one-cycle `alu_start` into the add/mul/div unit. It waits a fixed latency for add/mul, or for `alu_done` on divide, then returns the captured result with its tag. It sits between the test/control sequencer and the arithmetic top, so that no caller hand-times the unit.

Parameters:
- `WIDTH`, 32: operand/result width (signed Q8.23, sign-magnitude as used by the adder/multiplier).
- `TAG_W`, 4: request tag width, echoed on the response.
- `ADD_LAT`, 1: cycles from the `alu_start` cycle to a valid add result (1..15).
- `MUL_LAT`, 1: cycles from the `alu_start` cycle to a valid multiply result (1..15).
- `DIV_TIMEOUT`, 64: watchdog limit in cycles (used only with `FXP_DIV_TIMEOUT_EN`).

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: issuer can accept a request.
- `req_opcode` input 2: 00 add, 01 mul, 10 div, 11 illegal.
- `req_a` input WIDTH: operand a.
- `req_b` input WIDTH: operand b.
- `req_tag` input TAG_W: caller tag.
- `alu_a` output WIDTH: operand a to the arithmetic unit.
- `alu_b` output WIDTH: operand b to the arithmetic unit.
- `alu_opcode` output 2: opcode to the arithmetic unit.
- `alu_start` output 1: one-cycle start pulse.
- `alu_result` input WIDTH: result `c` from the unit.
- `alu_done` input 1: divide complete flag.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_result` output WIDTH: captured result.
- `rsp_tag` output TAG_W: echoed tag.
- `rsp_err` output 1: illegal opcode, or divide timeout.
- `busy` output 1: state is not IDLE.

Behaviour:
- One clock domain (`clk`). Reset is synchronous, active-high (`reset`).
- Reset values:
  - State is IDLE.
  - `req_ready` = 1.
  - `alu_start`, `rsp_valid`, `rsp_err` and `busy` = 0.
  - `alu_a`, `alu_b`, `rsp_result` = 0.
  - `alu_opcode` = 00; `rsp_tag` = 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready` = 1 only in this state.
  - On `req_valid` && `req_ready`, register a/b/opcode/tag into `alu_a`/`alu_b`/`alu_opcode`/tag register.
  - Opcode 11 goes directly to RESP with result 0 and `rsp_err` = 1; `alu_start` never asserts.
  - Otherwise go to ISSUE.
- ISSUE (cycle T):
  - `alu_start` = 1 for exactly this cycle.
  - Load the latency counter with `ADD_LAT` or `MUL_LAT` (div: clear the watchdog).
  - Go to WAIT.
- WAIT:
  - `alu_a`, `alu_b` and `alu_opcode` are held stable for the whole operation.
  - Add/mul: the counter decrements each cycle. On the edge ending cycle T+LAT, capture `alu_result` into `rsp_result`, go to RESP.
  - Div: capture on the first cycle after T in which `alu_done` = 1. `alu_done` during T itself is ignored (stale flag from a previous divide).
- RESP:
  - `rsp_valid` = 1; `rsp_result`, `rsp_tag` and `rsp_err` are held stable until `rsp_ready`.
  - On `rsp_valid` && `rsp_ready`, go to IDLE.
  - The next request is accepted no earlier than the following cycle (no bypass).
- Throughput: add with `ADD_LAT`=1 gives accept at edge A, start in cycle A+1, `rsp_valid` in cycle A+3.
- Reset mid-operation: immediate return to the reset values. A late `alu_done` arriving in IDLE is ignored. An unaccepted response is dropped.
- `rsp_ready` held low indefinitely: the issuer stalls in RESP and `req_ready` stays 0. No request is lost.
- Results are passed through unmodified; no width conversion or saturation.

Optional Feature:
- Macro: `FXP_DIV_TIMEOUT_EN`.
- Defined: a divide watchdog counts cycles in WAIT. If it reaches `DIV_TIMEOUT` without `alu_done`, go to RESP with `rsp_result` = 0 and `rsp_err` = 1. `alu_done` on the same cycle as the timeout takes priority (normal result, no error).
- Undefined: no watchdog; WAIT on a divide waits forever, and `rsp_err` is only set for opcode 11.

Decomposition:
- Package `fxp_pkg` holds:
  - the opcode typedef: OP_ADD=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_ILL=2'b11;
  - the state typedef (IDLE/ISSUE/WAIT/RESP);
  - the Q8.23 format constants (FRAC_BITS=23, WIDTH=32).
- One sub-module, `fxp_lat_counter`: loadable down-counter with zero flag. It is shared by the add/mul latency wait and the divide watchdog.

Test Plan:
1. Add: `req_a`=0x00C00000 (1.5), `req_b`=0x01200000 (2.25), tag 3, model unit `ADD_LAT`=1.
   - `alu_start` pulses once.
   - `rsp_result`=0x01E00000 (3.75), `rsp_tag`=3, `rsp_err`=0, `rsp_valid` 3 cycles after accept.
2. Mul: 0x00C00000 × 0x01000000 (2.0) → `rsp_result`=0x01800000 (3.0). `alu_a`/`alu_b` stay stable through WAIT.
3. Div: model asserts `alu_done` 20 cycles after start, result 0x00600000; a stale `alu_done` is also held high during the ISSUE cycle.
   - Stale done ignored.
   - `rsp_result`=0x00600000, captured exactly on the 20th cycle.
4. Opcode 11, tag 9 → no `alu_start`; `rsp_err`=1, `rsp_result`=0, `rsp_tag`=9.
5. Backpressure: hold `rsp_ready`=0 for 10 cycles with the next request pending.
   - Response fields stable, `req_ready`=0 throughout.
   - Second request accepted only after the handshake.
6. Reset asserted mid-divide, then `alu_done` pulses → outputs at reset values, no `rsp_valid`. With `FXP_DIV_TIMEOUT_EN`, a divide with no done → `rsp_err`=1 after 64 cycles.
